awg_multichannel_core: RTL and testbench
========================================

Name: awg_multichannel_core

Overview:
Parametrised multi-channel waveform engine that generalises the single-NCO, switch-driven datapath into NUM_CH independent channels. Each channel has its own tuning word, phase offset, waveform, duty, amplitude and burst settings, written through a shadowed register port. A commit strobe applies all pending settings phase-coherently. It sits between the UI/config logic and the DAC drivers; the sample rate is set by an external strobe.

Parameters:
NUM_CH, 2, number of channels
ACC_W, 32, phase accumulator width
PHASE_W, 12, phase index width (top bits of accumulator); must be >= DAC_W
DAC_W, 12, output sample width (unsigned, offset-binary)
BURST_W, 16, burst cycle counter width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
cfg_we  in  1  config write strobe
cfg_ch  in  CH_W=max(1,clog2(NUM_CH))  target channel
cfg_addr  in  3  register select
cfg_wdata  in  32  write data (LSB-aligned, truncated to field width)
commit  in  1  shadow->active transfer request, all channels
sample_en  in  1  one-cycle sample-rate strobe
dac_out  out  NUM_CH*DAC_W  channel n at [n*DAC_W +: DAC_W]
dac_valid  out  NUM_CH  one-cycle pulse per new sample
ch_busy  out  NUM_CH  channel in RUN or BURST
burst_done  out  NUM_CH  one-cycle pulse on entry to DONE

Behaviour:
- Register map (shadow): 0 tuning word ACC_W; 1 phase offset ACC_W; 2 wave sel [1:0] (00 sine, 01 saw, 10 tri, 11 square); 3 duty threshold PHASE_W; 4 amplitude DAC_W+1 bits, 2^DAC_W = unity, larger values clamp to unity; 5 burst count BURST_W, 0 = continuous; 6 ctrl: bit0 enable, bit1 restart phase on load. Addr 7 and cfg_ch >= NUM_CH: write ignored.
- Reset values: shadow and active hold tw 0, offset 0, sel 00, duty 2^(PHASE_W-1), amp 2^DAC_W, burst 0, ctrl 0. Accumulator 0, state IDLE, dac_out midscale 2^(DAC_W-1), dac_valid/ch_busy/burst_done 0.
- Commit sets a pending flag. On the next sample_en, including one in the same cycle, all channels load active from shadow simultaneously and the flag clears. A cfg write in the same cycle as that load is included in the load.
- On load: if ctrl.bit1 is set, acc <= 0. State re-evaluates: enable=0 -> IDLE; burst=0 -> RUN; else BURST with cnt <= burst.
- Per channel on sample_en (RUN/BURST): idx = (acc + offset)[ACC_W-1 -: PHASE_W]; acc <= acc + tw mod 2^ACC_W. The first sample after load uses the pre-increment acc.
- BURST: each accumulator carry-out decrements cnt. The carry that takes cnt to 0 moves the channel to DONE; that sample is still emitted; burst_done pulses. DONE and IDLE hold acc and emit midscale on each sample_en (dac_valid still pulses). DONE exits only via load.
- Pipeline: 3 stages, dac_valid 3 cycles after sample_en. S1 index; S2 shape; S3 scale.
- Shapes, with p = idx:
  - Saw: p[PHASE_W-1 -: DAC_W].
  - Tri: f = p[PHASE_W-1] ? ~p[PHASE_W-2:0] : p[PHASE_W-2:0]; output {f,1'b0} top DAC_W bits.
  - Square: p < duty ? 2^DAC_W-1 : 0.
  - Sine: quarter-wave ROM, sine(0)=2^(DAC_W-1), peak 2^DAC_W-1 at p=2^(PHASE_W-2).
- Scale: s = w - 2^(DAC_W-1) signed; out = 2^(DAC_W-1) + ((s*amp) >>> DAC_W), arithmetic shift (floor).
- sample_en while a previous sample is in flight: pipeline is fully pipelined, one sample per cycle max.
- Async rst mid-operation: immediate return to reset values; pending commit lost.

Decomposition:
- Package awg_pkg: waveform select encodings, register address constants, channel state enum (IDLE/RUN/BURST/DONE), midscale/unity helper functions.
- Sub-module awg_channel (NCO, state machine, 3-stage shaper/scaler, sine ROM), instantiated NUM_CH times by generate. The top level holds the shadow registers, commit flag and cfg decode.

Test Plan:
- Reset: assert rst -> dac_out both channels 2048, dac_valid/ch_busy/burst_done 0.
- Ch0: tw=0x0040_0000, sel=saw, ctrl=1, commit, sample_en every cycle -> ch_busy[0]=1; dac_out ch0 = 0,4,8,... with first dac_valid 3 cycles after the loading sample_en.
- Burst: ch0 tw=0x4000_0000, burst=2, ctrl=3, commit -> 8 samples saw 0,1024,2048,3072 x2, burst_done pulse on 8th, then midscale, ch_busy 0.
- Amplitude: square, duty 2048, amp 2048 -> samples alternate 3071 / 1024. amp 0x1FFF clamps -> 4095 / 0.
- Coherence: write new tw to ch0 and ch1, no commit -> outputs unchanged. Commit -> both channels switch on the same sample_en. A write in the commit cycle is applied.
- Assert rst mid-burst -> outputs midscale immediately, state IDLE, subsequent sample_en gives 2048 with no burst_done.

Source files
------------

// File: rtl/awg_pkg.sv
// Shared types and constants for the multi-channel waveform engine.
// Waveform selects, register addresses, channel states and level helpers.
package awg_pkg;

    typedef enum logic [1:0] {
        WAVE_SINE = 2'b00,
        WAVE_SAW  = 2'b01,
        WAVE_TRI  = 2'b10,
        WAVE_SQR  = 2'b11
    } wave_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_BURST,
        ST_DONE
    } ch_state_e;

    localparam logic [2:0] REG_TW    = 3'd0;
    localparam logic [2:0] REG_OFF   = 3'd1;
    localparam logic [2:0] REG_SEL   = 3'd2;
    localparam logic [2:0] REG_DUTY  = 3'd3;
    localparam logic [2:0] REG_AMP   = 3'd4;
    localparam logic [2:0] REG_BURST = 3'd5;
    localparam logic [2:0] REG_CTRL  = 3'd6;

    function automatic int midscale(int w);
        return 1 << (w - 1);
    endfunction

    function automatic int unity(int w);
        return 1 << w;
    endfunction

endpackage

// File: rtl/awg_channel.sv
// One waveform channel: NCO, run/burst state machine and a
// three-stage index/shape/scale pipeline with a quarter-wave sine ROM.
module awg_channel
    import awg_pkg::*;
#(
    parameter int ACC_W   = 32,
    parameter int PHASE_W = 12,
    parameter int DAC_W   = 12,
    parameter int BURST_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sample_en,
    input  logic               load,
    input  logic [ACC_W-1:0]   sh_tw,
    input  logic [ACC_W-1:0]   sh_off,
    input  logic [1:0]         sh_sel,
    input  logic [PHASE_W-1:0] sh_duty,
    input  logic [DAC_W:0]     sh_amp,
    input  logic [BURST_W-1:0] sh_burst,
    input  logic               sh_en,
    input  logic               sh_restart,
    output logic [DAC_W-1:0]   dac,
    output logic               dac_valid,
    output logic               busy,
    output logic               burst_done
);

    localparam int Q  = 1 << (PHASE_W - 2);
    localparam int PW = 2 * DAC_W + 2;
    localparam int MID = midscale(DAC_W);
    localparam logic [DAC_W-1:0] MID_V = DAC_W'(MID);
    localparam logic [DAC_W:0] UNITY_V = (DAC_W+1)'(unity(DAC_W));
    localparam logic [PHASE_W-1:0] DUTY_RST = PHASE_W'(midscale(PHASE_W));

    function automatic logic [DAC_W-2:0] sine_mag(int k);
        real x;
        real term;
        real acc;
        x = 1.57079632679489661923 * real'(k) / real'(Q);
        term = x;
        acc = x;
        for (int n = 1; n < 12; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            acc = acc + term;
        end
        return (DAC_W-1)'($rtoi(acc * real'(MID - 1) + 0.5));
    endfunction

    logic [DAC_W-2:0] rom [Q+1];

    for (genvar g = 0; g <= Q; g++) begin : g_rom
        assign rom[g] = sine_mag(g);
    end

    ch_state_e st_q, st_d, st_e;
    logic [ACC_W-1:0]   acc_q, acc_d, acc_b;
    logic [ACC_W-1:0]   tw_q, off_q, tw_e, off_e;
    logic [1:0]         sel_q, sel_e;
    logic [PHASE_W-1:0] duty_q, duty_e;
    logic [DAC_W:0]     amp_q, amp_e;
    logic [BURST_W-1:0] cnt_q, cnt_d, cnt_e;
    logic [ACC_W:0]     sum;
    logic [PHASE_W-1:0] idx;
    logic               run_e;
    logic               fin;

    // Settings written in the load cycle already govern that sample.
    assign tw_e   = load ? sh_tw   : tw_q;
    assign off_e  = load ? sh_off  : off_q;
    assign sel_e  = load ? sh_sel  : sel_q;
    assign duty_e = load ? sh_duty : duty_q;
    assign amp_e  = load ? sh_amp  : amp_q;
    assign acc_b  = (load && sh_restart) ? '0 : acc_q;

    always_comb begin
        st_e  = st_q;
        cnt_e = cnt_q;
        if (load) begin
            cnt_e = sh_burst;
            if (!sh_en)
                st_e = ST_IDLE;
            else if (sh_burst == '0)
                st_e = ST_RUN;
            else
                st_e = ST_BURST;
        end
    end

    assign run_e = (st_e == ST_RUN) || (st_e == ST_BURST);
    assign sum   = {1'b0, acc_b} + {1'b0, tw_e};
    assign idx   = PHASE_W'((acc_b + off_e) >> (ACC_W - PHASE_W));

    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        acc_d = acc_q;
        fin   = 1'b0;
        if (sample_en) begin
            st_d  = st_e;
            cnt_d = cnt_e;
            acc_d = acc_b;
            if (run_e) begin
                acc_d = sum[ACC_W-1:0];
                if (st_e == ST_BURST && sum[ACC_W]) begin
                    cnt_d = cnt_e - BURST_W'(1);
                    if (cnt_e == BURST_W'(1)) begin
                        st_d = ST_DONE;
                        fin  = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q   <= ST_IDLE;
            acc_q  <= '0;
            cnt_q  <= '0;
            tw_q   <= '0;
            off_q  <= '0;
            sel_q  <= WAVE_SINE;
            duty_q <= DUTY_RST;
            amp_q  <= UNITY_V;
        end else begin
            st_q  <= st_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            if (load) begin
                tw_q   <= sh_tw;
                off_q  <= sh_off;
                sel_q  <= sh_sel;
                duty_q <= sh_duty;
                amp_q  <= sh_amp;
            end
        end
    end

    assign busy = (st_q == ST_RUN) || (st_q == ST_BURST);

    logic               s1_vld, s1_mid, s1_fin;
    logic [PHASE_W-1:0] s1_idx, s1_duty;
    logic [1:0]         s1_sel;
    logic [DAC_W:0]     s1_amp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_mid  <= 1'b0;
            s1_fin  <= 1'b0;
            s1_idx  <= '0;
            s1_sel  <= WAVE_SINE;
            s1_duty <= DUTY_RST;
            s1_amp  <= UNITY_V;
        end else begin
            s1_vld  <= sample_en;
            s1_mid  <= !run_e;
            s1_fin  <= fin;
            s1_idx  <= idx;
            s1_sel  <= sel_e;
            s1_duty <= duty_e;
            s1_amp  <= (amp_e > UNITY_V) ? UNITY_V : amp_e;
        end
    end

    logic [PHASE_W-2:0] tri_f;
    logic [PHASE_W-2:0] rom_a;
    logic [DAC_W-2:0]   mag;
    logic [DAC_W-1:0]   sine_w, w;

    // Odd quadrants read the ROM mirrored; the upper half is negated.
    assign tri_f = s1_idx[PHASE_W-1] ? ~s1_idx[PHASE_W-2:0]
                                     : s1_idx[PHASE_W-2:0];
    assign rom_a = s1_idx[PHASE_W-2]
                 ? (PHASE_W-1)'(Q) - {1'b0, s1_idx[PHASE_W-3:0]}
                 : {1'b0, s1_idx[PHASE_W-3:0]};
    assign mag    = rom[rom_a];
    assign sine_w = s1_idx[PHASE_W-1] ? MID_V - DAC_W'(mag)
                                      : MID_V + DAC_W'(mag);

    always_comb begin
        w = MID_V;
        unique case (s1_sel)
            WAVE_SAW:  w = DAC_W'(s1_idx >> (PHASE_W - DAC_W));
            WAVE_TRI:  w = DAC_W'({tri_f, 1'b0} >> (PHASE_W - DAC_W));
            WAVE_SQR:  w = (s1_idx < s1_duty) ? '1 : '0;
            WAVE_SINE: w = sine_w;
        endcase
        if (s1_mid)
            w = MID_V;
    end

    logic             s2_vld, s2_fin;
    logic [DAC_W-1:0] s2_w;
    logic [DAC_W:0]   s2_amp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_vld <= 1'b0;
            s2_fin <= 1'b0;
            s2_w   <= MID_V;
            s2_amp <= UNITY_V;
        end else begin
            s2_vld <= s1_vld;
            s2_fin <= s1_fin;
            s2_w   <= w;
            s2_amp <= s1_amp;
        end
    end

    logic signed [DAC_W:0] s;
    logic signed [PW-1:0]  prod, scl, tot;

    assign s    = $signed({1'b0, s2_w}) - $signed((DAC_W+1)'(MID));
    assign prod = PW'(s) * PW'($signed({1'b0, s2_amp}));
    assign scl  = prod >>> DAC_W;
    assign tot  = scl + PW'(MID);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dac        <= MID_V;
            dac_valid  <= 1'b0;
            burst_done <= 1'b0;
        end else begin
            dac_valid  <= s2_vld;
            burst_done <= s2_fin;
            if (s2_vld)
                dac <= DAC_W'(tot);
        end
    end

endmodule

// File: rtl/awg_multichannel_core.sv
// Multi-channel waveform engine: shadow register file, commit flag
// and config decode in front of NUM_CH independent channels.
module awg_multichannel_core
    import awg_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int ACC_W   = 32,
    parameter int PHASE_W = 12,
    parameter int DAC_W   = 12,
    parameter int BURST_W = 16,
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_we,
    input  logic [CH_W-1:0]         cfg_ch,
    input  logic [2:0]              cfg_addr,
    input  logic [31:0]             cfg_wdata,
    input  logic                    commit,
    input  logic                    sample_en,
    output logic [NUM_CH*DAC_W-1:0] dac_out,
    output logic [NUM_CH-1:0]       dac_valid,
    output logic [NUM_CH-1:0]       ch_busy,
    output logic [NUM_CH-1:0]       burst_done
);

    localparam logic [PHASE_W-1:0] DUTY_RST = PHASE_W'(midscale(PHASE_W));
    localparam logic [DAC_W:0] AMP_RST = (DAC_W+1)'(unity(DAC_W));

    logic [ACC_W-1:0]   tw_q   [NUM_CH];
    logic [ACC_W-1:0]   tw_d   [NUM_CH];
    logic [ACC_W-1:0]   off_q  [NUM_CH];
    logic [ACC_W-1:0]   off_d  [NUM_CH];
    wave_e              sel_q  [NUM_CH];
    wave_e              sel_d  [NUM_CH];
    logic [PHASE_W-1:0] duty_q [NUM_CH];
    logic [PHASE_W-1:0] duty_d [NUM_CH];
    logic [DAC_W:0]     amp_q  [NUM_CH];
    logic [DAC_W:0]     amp_d  [NUM_CH];
    logic [BURST_W-1:0] bst_q  [NUM_CH];
    logic [BURST_W-1:0] bst_d  [NUM_CH];
    logic [1:0]         ctl_q  [NUM_CH];
    logic [1:0]         ctl_d  [NUM_CH];

    logic ch_ok;
    logic pend_q;
    logic load;

    assign ch_ok = (32'(cfg_ch) < NUM_CH);
    assign load  = sample_en && (pend_q || commit);

    // The _d views include this cycle's write, so a write that
    // lands together with the load is part of it.
    always_comb begin
        tw_d   = tw_q;
        off_d  = off_q;
        sel_d  = sel_q;
        duty_d = duty_q;
        amp_d  = amp_q;
        bst_d  = bst_q;
        ctl_d  = ctl_q;
        if (cfg_we && ch_ok) begin
            case (cfg_addr)
                REG_TW:    tw_d[cfg_ch]   = cfg_wdata[ACC_W-1:0];
                REG_OFF:   off_d[cfg_ch]  = cfg_wdata[ACC_W-1:0];
                REG_SEL:   sel_d[cfg_ch]  = wave_e'(cfg_wdata[1:0]);
                REG_DUTY:  duty_d[cfg_ch] = cfg_wdata[PHASE_W-1:0];
                REG_AMP:   amp_d[cfg_ch]  = cfg_wdata[DAC_W:0];
                REG_BURST: bst_d[cfg_ch]  = cfg_wdata[BURST_W-1:0];
                REG_CTRL:  ctl_d[cfg_ch]  = cfg_wdata[1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                tw_q[i]   <= '0;
                off_q[i]  <= '0;
                sel_q[i]  <= WAVE_SINE;
                duty_q[i] <= DUTY_RST;
                amp_q[i]  <= AMP_RST;
                bst_q[i]  <= '0;
                ctl_q[i]  <= '0;
            end
        end else begin
            pend_q <= load ? 1'b0 : (pend_q || commit);
            tw_q   <= tw_d;
            off_q  <= off_d;
            sel_q  <= sel_d;
            duty_q <= duty_d;
            amp_q  <= amp_d;
            bst_q  <= bst_d;
            ctl_q  <= ctl_d;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        awg_channel #(
            .ACC_W   (ACC_W),
            .PHASE_W (PHASE_W),
            .DAC_W   (DAC_W),
            .BURST_W (BURST_W)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .sample_en  (sample_en),
            .load       (load),
            .sh_tw      (tw_d[c]),
            .sh_off     (off_d[c]),
            .sh_sel     (sel_d[c]),
            .sh_duty    (duty_d[c]),
            .sh_amp     (amp_d[c]),
            .sh_burst   (bst_d[c]),
            .sh_en      (ctl_d[c][0]),
            .sh_restart (ctl_d[c][1]),
            .dac        (dac_out[c*DAC_W +: DAC_W]),
            .dac_valid  (dac_valid[c]),
            .busy       (ch_busy[c]),
            .burst_done (burst_done[c])
        );
    end

endmodule

// File: tb/tb_awg_multichannel_core.sv
// Randomised bench for awg_multichannel_core against an
// arithmetic reference model of the channel behaviour.
module tb_awg_multichannel_core;

    localparam int NUM_CH = 2;
    localparam longint TWO32 = 64'h1_0000_0000;
    localparam real PI = 3.14159265358979323846;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [0:0]  cfg_ch;
    logic [2:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic        commit;
    logic        sample_en;
    logic [23:0] dac_out;
    logic [1:0]  dac_valid;
    logic [1:0]  ch_busy;
    logic [1:0]  burst_done;

    awg_multichannel_core #(
        .NUM_CH(2), .ACC_W(32), .PHASE_W(12), .DAC_W(12), .BURST_W(16)
    ) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .commit(commit),
        .sample_en(sample_en), .dac_out(dac_out), .dac_valid(dac_valid),
        .ch_busy(ch_busy), .burst_done(burst_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: shadow (s_*), active (a_*), NCO and state.
    // State codes: 0 idle, 1 run, 2 burst, 3 done.
    longint s_tw[NUM_CH], s_off[NUM_CH], a_tw[NUM_CH], a_off[NUM_CH];
    int s_sel[NUM_CH], s_duty[NUM_CH], s_amp[NUM_CH], s_bst[NUM_CH];
    int s_ctl[NUM_CH];
    int a_sel[NUM_CH], a_duty[NUM_CH], a_amp[NUM_CH];
    longint m_acc[NUM_CH];
    int m_st[NUM_CH], m_cnt[NUM_CH];
    bit m_pend;
    bit pv[3][NUM_CH];
    bit pf[3][NUM_CH];
    int pd[3][NUM_CH];
    int e_dac[NUM_CH];

    function automatic int shape(int sel, int p, int duty);
        real v;
        case (sel)
            1: return p;
            2: return (p < 2048) ? 2 * p : 2 * (4095 - p);
            3: return (p < duty) ? 4095 : 0;
            default: begin
                v = 2047.0 * $sin(2.0 * PI * real'(p) / 4096.0);
                if (v >= 0.0) return 2048 + $rtoi(v + 0.5);
                return 2048 - $rtoi(-v + 0.5);
            end
        endcase
    endfunction

    function automatic int scale(int w, int amp);
        int a, n, q;
        a = (amp > 4096) ? 4096 : amp;
        n = (w - 2048) * a;
        q = n / 4096;
        if (n < 0 && (n % 4096) != 0) q = q - 1;
        return 2048 + q;
    endfunction

    task automatic model_reset();
        m_pend = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            s_tw[c] = 0; s_off[c] = 0; s_sel[c] = 0; s_duty[c] = 2048;
            s_amp[c] = 4096; s_bst[c] = 0; s_ctl[c] = 0;
            a_tw[c] = 0; a_off[c] = 0; a_sel[c] = 0; a_duty[c] = 2048;
            a_amp[c] = 4096;
            m_acc[c] = 0; m_st[c] = 0; m_cnt[c] = 0; e_dac[c] = 2048;
            for (int k = 0; k < 3; k++) begin
                pv[k][c] = 0; pf[k][c] = 0; pd[k][c] = 2048;
            end
        end
    endtask

    task automatic model_step();
        bit ld;
        int c;
        longint sum;
        int p;
        ld = sample_en && (m_pend || commit);
        if (cfg_we && cfg_addr != 3'd7) begin
            c = int'(cfg_ch);
            case (cfg_addr)
                3'd0: s_tw[c] = longint'(cfg_wdata);
                3'd1: s_off[c] = longint'(cfg_wdata);
                3'd2: s_sel[c] = int'(cfg_wdata & 32'h3);
                3'd3: s_duty[c] = int'(cfg_wdata & 32'hFFF);
                3'd4: s_amp[c] = int'(cfg_wdata & 32'h1FFF);
                3'd5: s_bst[c] = int'(cfg_wdata & 32'hFFFF);
                default: s_ctl[c] = int'(cfg_wdata & 32'h3);
            endcase
        end
        m_pend = ld ? 1'b0 : (m_pend || commit);
        pv[2] = pv[1]; pf[2] = pf[1]; pd[2] = pd[1];
        pv[1] = pv[0]; pf[1] = pf[0]; pd[1] = pd[0];
        for (int ch = 0; ch < NUM_CH; ch++) begin
            pv[0][ch] = 0; pf[0][ch] = 0; pd[0][ch] = 2048;
            if (ld) begin
                a_tw[ch] = s_tw[ch]; a_off[ch] = s_off[ch];
                a_sel[ch] = s_sel[ch]; a_duty[ch] = s_duty[ch];
                a_amp[ch] = s_amp[ch];
                if (s_ctl[ch] >= 2) m_acc[ch] = 0;
                if ((s_ctl[ch] % 2) == 0) m_st[ch] = 0;
                else if (s_bst[ch] == 0) m_st[ch] = 1;
                else m_st[ch] = 2;
                m_cnt[ch] = s_bst[ch];
            end
            if (sample_en) begin
                pv[0][ch] = 1;
                if (m_st[ch] == 1 || m_st[ch] == 2) begin
                    p = int'(((m_acc[ch] + a_off[ch]) % TWO32) / 1048576);
                    pd[0][ch] = scale(shape(a_sel[ch], p, a_duty[ch]),
                                      a_amp[ch]);
                    sum = m_acc[ch] + a_tw[ch];
                    m_acc[ch] = sum % TWO32;
                    if (m_st[ch] == 2 && sum >= TWO32) begin
                        m_cnt[ch]--;
                        if (m_cnt[ch] == 0) begin
                            m_st[ch] = 3;
                            pf[0][ch] = 1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic compare_outputs();
        logic [1:0] ev, ef, eb;
        logic [23:0] ed;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (pv[2][ch]) e_dac[ch] = pd[2][ch];
            ev[ch] = pv[2][ch];
            ef[ch] = pf[2][ch];
            eb[ch] = (m_st[ch] == 1 || m_st[ch] == 2);
            ed[ch*12 +: 12] = 12'(e_dac[ch]);
        end
        check("dac_valid", dac_valid, ev);
        check("dac_out", dac_out, ed);
        check("burst_done", burst_done, ef);
        check("ch_busy", ch_busy, eb);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    task automatic idle_in();
        cfg_we = 0; cfg_ch = 0; cfg_addr = 0; cfg_wdata = 0;
        commit = 0; sample_en = 0;
    endtask

    task automatic wr(input int ch, input int addr, input logic [31:0] d,
                      input bit se, input bit cm);
        cfg_we = 1; cfg_ch = 1'(ch); cfg_addr = 3'(addr);
        cfg_wdata = d; sample_en = se; commit = cm;
        tick();
        idle_in();
    endtask

    task automatic run(input int n, input bit cm);
        for (int i = 0; i < n; i++) begin
            sample_en = 1;
            commit = (i == 0) ? cm : 1'b0;
            tick();
        end
        idle_in();
    endtask

    task automatic check_reset_levels(input string tag);
        check({tag, "_dac"}, dac_out, {12'd2048, 12'd2048});
        check({tag, "_valid"}, dac_valid, 2'b00);
        check({tag, "_busy"}, ch_busy, 2'b00);
        check({tag, "_done"}, burst_done, 2'b00);
    endtask

    initial begin
        idle_in();
        rst = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_levels("reset");
        rst = 0;

        // Saw on ch0, continuous.
        wr(0, 0, 32'h0040_0000, 0, 0);
        wr(0, 2, 32'd1, 0, 0);
        wr(0, 6, 32'd1, 0, 1);
        run(20, 0);
        check("saw_busy", ch_busy, 2'b01);

        // Burst of two cycles, restart phase.
        wr(0, 0, 32'h4000_0000, 0, 0);
        wr(0, 5, 32'd2, 0, 0);
        wr(0, 6, 32'd3, 0, 0);
        run(14, 1);
        check("burst_end_busy", ch_busy, 2'b00);

        // Square on ch1, unity-half amplitude then clamped.
        wr(1, 0, 32'h8000_0000, 0, 0);
        wr(1, 2, 32'd3, 0, 0);
        wr(1, 3, 32'd2048, 0, 0);
        wr(1, 4, 32'd2048, 0, 0);
        wr(1, 6, 32'd1, 0, 1);
        run(8, 0);
        wr(1, 4, 32'h1FFF, 0, 1);
        run(8, 0);

        // Coherent update, including a write in the commit cycle.
        wr(0, 6, 32'd1, 1, 0);
        wr(0, 0, 32'h0100_0000, 1, 0);
        wr(1, 0, 32'h0200_0000, 1, 0);
        run(6, 0);
        wr(0, 0, 32'h0300_0000, 1, 1);
        run(8, 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            int a;
            logic [31:0] d;
            a = $urandom_range(0, 7);
            case (a)
                0: d = $urandom >> $urandom_range(0, 10);
                4: d = $urandom_range(0, 8191);
                5: d = $urandom_range(0, 3);
                default: d = $urandom;
            endcase
            cfg_we = ($urandom_range(0, 3) == 0);
            cfg_ch = 1'($urandom_range(0, 1));
            cfg_addr = 3'(a);
            cfg_wdata = d;
            commit = ($urandom_range(0, 15) == 0);
            sample_en = ($urandom_range(0, 1) == 1);
            tick();
        end
        idle_in();
        run(4, 0);

        // Reset in the middle of a long burst.
        wr(0, 0, 32'h1000_0000, 0, 0);
        wr(0, 5, 32'd100, 0, 0);
        wr(0, 6, 32'd3, 0, 1);
        run(10, 0);
        sample_en = 1;
        rst = 1;
        #1;
        check_reset_levels("midrst");
        model_reset();
        sample_en = 0;
        @(posedge clk);
        #1;
        rst = 0;
        run(6, 0);
        check("post_rst_busy", ch_busy, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
